// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
//   Quadrature (A/B) decoder with a two-flop input synchronizer, a
//   five-state decode FSM, a modulo-16 position counter and a sticky
//   illegal-transition flag.
//
//   Optional feature macro: QDEC_FILTER_EN
//     When defined, a synchronized {A,B} value is accepted only after it
//     has been identical for FILT_LEN consecutive cycles. When undefined,
//     the synchronized value is accepted every cycle and FILT_LEN is unused.
//
// Ports
//   Clk      in   1  clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   A, B     in   1  quadrature channels, asynchronous to Clk
//   clr      in   1  synchronous clear of Count and Err
//   Step     out  1  one-cycle pulse per accepted valid step
//   UpOrDown out  1  direction of last valid step (1 = up)
//   Count    out  4  position count, modulo 16
//   Err      out  1  sticky illegal-transition flag
// ---------------------------------------------------------------------------
module quad_decoder #(
  parameter int FILT_LEN = 4
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  input  logic       clr,
  output logic       Step,
  output logic       UpOrDown,
  output logic [3:0] Count,
  output logic       Err
);

  typedef enum logic [2:0] {
    INIT = 3'd0,
    S00  = 3'd1,
    S10  = 3'd2,
    S11  = 3'd3,
    S01  = 3'd4
  } state_t;

  // Next {A,B} in the up direction: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    logic [1:0] nx;
    case (ab)
      2'b00:   nx = 2'b10;
      2'b10:   nx = 2'b11;
      2'b11:   nx = 2'b01;
      2'b01:   nx = 2'b00;
      default: nx = 2'b00;
    endcase
    return nx;
  endfunction

  function automatic state_t ab_to_state(input logic [1:0] ab);
    state_t st;
    case (ab)
      2'b00:   st = S00;
      2'b10:   st = S10;
      2'b11:   st = S11;
      2'b01:   st = S01;
      default: st = S00;
    endcase
    return st;
  endfunction

  function automatic logic [1:0] state_to_ab(input state_t st);
    logic [1:0] ab;
    case (st)
      S00:     ab = 2'b00;
      S10:     ab = 2'b10;
      S11:     ab = 2'b11;
      S01:     ab = 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  logic [1:0] sync1_r;
  logic [1:0] sync2_r;
  // sync_vld_r marks when the synchronizer holds real pin samples rather
  // than its reset zeros, so priming never latches the flushed value.
  logic [1:0] sync_vld_r;
  logic       accept_s;

  state_t     state_r;
  state_t     state_nx_s;
  logic       step_nx_s;
  logic       dir_nx_s;
  logic [3:0] count_nx_s;
  logic       err_nx_s;
  logic [1:0] cur_ab_s;

  // Two-flop synchronizer for A/B plus the sample-valid shift chain.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sync1_r    <= 2'b00;
      sync2_r    <= 2'b00;
      sync_vld_r <= 2'b00;
    end else begin
      sync1_r    <= {A, B};
      sync2_r    <= sync1_r;
      sync_vld_r <= {sync_vld_r[0], 1'b1};
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    filt_last_r;
  logic [CW-1:0] filt_cnt_r;
  logic          filt_stable_s;

  // filt_cnt_r counts cycles the synchronized value has matched its
  // previous sample; reaching FILT_LEN-1 means FILT_LEN identical cycles.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      filt_last_r <= 2'b00;
      filt_cnt_r  <= '0;
    end else begin
      filt_last_r <= sync2_r;
      if (sync2_r != filt_last_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r < CW'(FILT_LEN - 1)) begin
        filt_cnt_r <= filt_cnt_r + CW'(1);
      end else begin
        filt_cnt_r <= filt_cnt_r;
      end
    end
  end

  assign filt_stable_s = (sync2_r == filt_last_r) &&
                         (filt_cnt_r >= CW'(FILT_LEN - 1));
  assign accept_s      = sync_vld_r[1] & filt_stable_s;
`else
  logic unused_filt_s;
  assign unused_filt_s = (FILT_LEN > 0);
  assign accept_s      = sync_vld_r[1];
`endif

  assign cur_ab_s = state_to_ab(state_r);

  // Decode FSM next state and next registered outputs.
  always_comb begin
    state_nx_s = state_r;
    step_nx_s  = 1'b0;
    dir_nx_s   = UpOrDown;
    count_nx_s = Count;
    err_nx_s   = Err;

    if (accept_s) begin
      case (state_r)
        INIT: begin
          state_nx_s = ab_to_state(sync2_r);
        end
        default: begin
          if (sync2_r == cur_ab_s) begin
            state_nx_s = state_r;
          end else if (sync2_r == fwd_next(cur_ab_s)) begin
            state_nx_s = ab_to_state(sync2_r);
            step_nx_s  = 1'b1;
            dir_nx_s   = 1'b1;
            count_nx_s = Count + 4'd1;
          end else if (cur_ab_s == fwd_next(sync2_r)) begin
            state_nx_s = ab_to_state(sync2_r);
            step_nx_s  = 1'b1;
            dir_nx_s   = 1'b0;
            count_nx_s = Count - 4'd1;
          end else begin
            // Both bits changed: direction is unknowable, so only flag it.
            state_nx_s = ab_to_state(sync2_r);
            err_nx_s   = 1'b1;
          end
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end

    // clr overrides the counter and flag but not Step, direction or state.
    if (clr) begin
      count_nx_s = 4'd0;
      err_nx_s   = 1'b0;
    end else begin
      count_nx_s = count_nx_s;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_r  <= INIT;
      Step     <= 1'b0;
      UpOrDown <= 1'b1;
      Count    <= 4'd0;
      Err      <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      Step     <= step_nx_s;
      UpOrDown <= dir_nx_s;
      Count    <= count_nx_s;
      Err      <= err_nx_s;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder
//   Scoreboard bench for quad_decoder. Stimulus tasks drive A/B levels and
//   push the expected Step event (cycle, direction, count, flag) computed by
//   a position/Gray-index model; a monitor pops and compares on every Step.
// ---------------------------------------------------------------------------
module tb_quad_decoder;

  localparam int FILT_LEN = 4;
`ifdef QDEC_FILTER_EN
  localparam int LAT = 3 + FILT_LEN;
`else
  localparam int LAT = 3;
`endif

  logic       Clk = 1'b0;
  logic       reset;
  logic       A;
  logic       B;
  logic       clr;
  logic       Step;
  logic       UpOrDown;
  logic [3:0] Count;
  logic       Err;

  quad_decoder #(.FILT_LEN(FILT_LEN)) dut (
    .Clk(Clk), .reset(reset), .A(A), .B(B), .clr(clr),
    .Step(Step), .UpOrDown(UpOrDown), .Count(Count), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       dir;
    logic [3:0] cnt;
    logic       err;
  } ev_t;
  ev_t q[$];

  int checks = 0;
  int passes = 0;

  // Reference model: position, last direction, sticky flag, Gray index.
  int   m_pos;
  logic m_dir;
  logic m_err;
  int   m_idx;

  function automatic int gray_idx(input logic [1:0] v);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, Count, m_pos);
    check({tag, "_dir"}, UpOrDown, m_dir);
    check({tag, "_err"}, Err, m_err);
  endtask

  // Monitor: every Step must match the oldest expected event.
  always @(negedge Clk) begin
    if (!reset && Step) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_step: Step=1 at cycle %0d with no step expected", cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("step_cycle", cyc, e.at);
        check("step_dir", UpOrDown, e.dir);
        check("step_count", Count, e.cnt);
        check("step_err", Err, e.err);
      end
    end
  end

  task automatic do_reset(input logic [1:0] ab);
    @(negedge Clk);
    reset = 1'b1;
    clr   = 1'b0;
    {A, B} = ab;
    #1;
    check("rst_step", Step, 0);
    check("rst_dir", UpOrDown, 1);
    check("rst_count", Count, 0);
    check("rst_err", Err, 0);
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    q.delete();
    m_idx = gray_idx(ab);
    m_pos = 0;
    m_dir = 1'b1;
    m_err = 1'b0;
    repeat (LAT + 3) @(negedge Clk);
    check_status("prime");
  endtask

  // Drive a new level, hold it for 'hold' cycles (hold >= LAT), optionally
  // asserting clr in the decode cycle of this change.
  task automatic apply(input logic [1:0] ab, input int hold, input bit do_clr);
    int  n;
    int  d;
    bit  stepped;
    @(negedge Clk);
    {A, B} = ab;
    n = cyc;
    stepped = 1'b0;
    d = (gray_idx(ab) - m_idx + 4) % 4;
    if (d == 1) begin
      m_pos = (m_pos + 1) % 16; m_dir = 1'b1; stepped = 1'b1;
    end else if (d == 3) begin
      m_pos = (m_pos + 15) % 16; m_dir = 1'b0; stepped = 1'b1;
    end else if (d == 2) begin
      m_err = 1'b1;
    end
    m_idx = gray_idx(ab);
    if (do_clr) begin
      m_pos = 0;
      m_err = 1'b0;
    end
    if (stepped) q.push_back('{n + LAT, m_dir, 4'(m_pos), m_err});
    if (do_clr) begin
      repeat (LAT - 1) @(negedge Clk);
      clr = 1'b1;
      @(negedge Clk);
      clr = 1'b0;
      repeat (hold - LAT) @(negedge Clk);
    end else begin
      repeat (hold) @(negedge Clk);
    end
    check_status("hold");
  endtask

  initial begin
    reset = 1'b1;
    clr   = 1'b0;
    A     = 1'b1;
    B     = 1'b1;

    // Prime with 11 held, then 00 is a double change.
    do_reset(2'b11);
    apply(2'b00, LAT + 2, 1'b0);
    apply(2'b00, LAT + 2, 1'b1);

    // Forward cycle, 8 cycles per level.
    apply(2'b10, 8, 1'b0);
    apply(2'b11, 8, 1'b0);
    apply(2'b01, 8, 1'b0);
    apply(2'b00, 8, 1'b0);

    // Reverse from zero: 15, 14, 13.
    do_reset(2'b00);
    apply(2'b01, LAT + 2, 1'b0);
    apply(2'b11, LAT + 2, 1'b0);
    apply(2'b10, LAT + 2, 1'b0);

    // Up to 15, then an up step with clr in its decode cycle, then one more.
    apply(2'b11, LAT + 2, 1'b0);
    apply(2'b01, LAT + 2, 1'b0);
    apply(2'b00, LAT + 2, 1'b1);
    apply(2'b10, LAT + 2, 1'b0);

    // Reset one cycle after a pin change: the step must be discarded.
    @(negedge Clk);
    {A, B} = 2'b11;
    @(negedge Clk);
    reset = 1'b1;
    #1;
    check("inflight_step", Step, 0);
    check("inflight_count", Count, 0);
    check("inflight_dir", UpOrDown, 1);
    check("inflight_err", Err, 0);
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    m_idx = gray_idx(2'b11);
    m_pos = 0;
    m_dir = 1'b1;
    m_err = 1'b0;
    repeat (LAT + 6) @(negedge Clk);
    check_status("inflight_after");

`ifdef QDEC_FILTER_EN
    // A 2-cycle glitch on A is shorter than the filter and must vanish.
    @(negedge Clk);
    A = ~A;
    repeat (2) @(negedge Clk);
    A = ~A;
    repeat (LAT + 4) @(negedge Clk);
    check_status("glitch");
    apply(2'b01, LAT + 2, 1'b0);
`endif

    // Randomized levels, including repeats, double changes and clr.
    for (int i = 0; i < 60; i++) begin
      apply(2'($urandom_range(0, 3)), LAT + 1 + $urandom_range(0, 4),
            ($urandom_range(0, 5) == 0));
    end

    repeat (LAT + 3) @(negedge Clk);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
